// File: rtl/kpn_mult_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// kpn_mult_scheduler_pkg
//   Shared definitions for the KPN multiplier scheduler: datapath widths,
//   scheduler FSM state encoding and a small sizing helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package kpn_mult_scheduler_pkg;

    localparam int KPN_OP_W  = 16;   // operand word width
    localparam int KPN_RES_W = 32;   // product word width

    // Encodings match the legacy IDLE/ISSUE/WAIT/WRITE values.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } sched_state_t;

    // $clog2 with a floor of 1 so single-entry indices still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kpn_mult_scheduler_rr_picker.sv
// -----------------------------------------------------------------------------
// kpn_rr_picker
//   Combinational round-robin picker. Starting at i_ptr and wrapping at
//   NUM_REQ-1, returns the first channel whose eligible bit is set.
// Ports
//   i_eligible  in   NUM_REQ  per-channel eligible flags
//   i_ptr       in   IDX_W    channel with highest priority this round
//   o_found     out  1        at least one channel is eligible
//   o_index     out  IDX_W    chosen channel (0 when o_found is low)
// -----------------------------------------------------------------------------
module kpn_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    int unsigned      w_pos;
    logic             w_found;
    logic [IDX_W-1:0] w_index;

    always_comb begin
        w_pos   = '0;
        w_found = 1'b0;
        w_index = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = (32'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_eligible[w_pos[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_index = w_pos[IDX_W-1:0];
            end
        end
    end

    assign o_found = w_found;
    assign o_index = w_index;

endmodule

// File: rtl/kpn_mult_scheduler.sv
// -----------------------------------------------------------------------------
// kpn_mult_scheduler
//   Round-robin scheduler sharing one multiplier between NUM_REQ KPN channels.
//   A granted channel has its operand pair popped, the pair is held on the
//   multiplier inputs for MUL_LATENCY cycles, and the product is pushed to
//   that channel's result FIFO (stalling while it is full).
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_empty_a/in_empty_b per-channel operand FIFO empty flags
//   in_a/in_b             per-channel operand head words, channel i at [16*i+:16]
//   rd                    one-hot operand pop pulse (both FIFOs of a channel)
//   out_full              per-channel result FIFO full
//   wr                    one-hot result push pulse
//   out_data              result word shared by all result FIFOs
//   mul_a/mul_b           operands to the shared multiplier
//   mul_result            product from the shared multiplier
//   grant_id              channel currently owning the multiplier
//   busy                  high whenever the FSM is not idle
//   op_count              completed operations, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module kpn_mult_scheduler
    import kpn_mult_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 16,
    localparam int GID_W      = clog2_min1(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_empty_a,
    input  logic [NUM_REQ-1:0]            in_empty_b,
    input  logic [KPN_OP_W*NUM_REQ-1:0]   in_a,
    input  logic [KPN_OP_W*NUM_REQ-1:0]   in_b,
    output logic [NUM_REQ-1:0]            rd,
    input  logic [NUM_REQ-1:0]            out_full,
    output logic [NUM_REQ-1:0]            wr,
    output logic [KPN_RES_W-1:0]          out_data,
    output logic [KPN_OP_W-1:0]           mul_a,
    output logic [KPN_OP_W-1:0]           mul_b,
    input  logic [KPN_RES_W-1:0]          mul_result,
    output logic [GID_W-1:0]              grant_id,
    output logic                          busy,
    output logic [CNT_W-1:0]              op_count
);

    localparam int LAT_W = clog2_min1(MUL_LATENCY);

    sched_state_t          r_state;
    logic [GID_W-1:0]      r_grant;
    logic [GID_W-1:0]      r_ptr;
    logic [LAT_W-1:0]      r_lat;
    logic [KPN_OP_W-1:0]   r_mul_a;
    logic [KPN_OP_W-1:0]   r_mul_b;
    logic [KPN_RES_W-1:0]  r_out;
    logic [CNT_W-1:0]      r_cnt;

    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_pick_found;
    logic [GID_W-1:0]      w_pick_idx;
    logic [KPN_OP_W-1:0]   w_pick_a;
    logic [KPN_OP_W-1:0]   w_pick_b;
    logic [NUM_REQ-1:0]    w_grant_oh;
    logic                  w_out_ready;
    logic [GID_W-1:0]      w_next_ptr;

    // Result-FIFO fullness is deliberately not part of eligibility; a full
    // result FIFO only stalls the WRITE state of an already granted op.
    assign w_eligible = ~in_empty_a & ~in_empty_b;

    kpn_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_found    (w_pick_found),
        .o_index    (w_pick_idx)
    );

    assign w_pick_a = in_a[32'(w_pick_idx)*KPN_OP_W +: KPN_OP_W];
    assign w_pick_b = in_b[32'(w_pick_idx)*KPN_OP_W +: KPN_OP_W];

    assign w_grant_oh  = NUM_REQ'(1) << r_grant;
    assign w_out_ready = ~out_full[r_grant];
    assign w_next_ptr  = (r_grant == GID_W'(NUM_REQ - 1)) ? '0 : r_grant + GID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_lat   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Operands are captured here, so an operand FIFO that
                    // drains after the grant cannot disturb this op.
                    if (w_pick_found) begin
                        r_grant <= w_pick_idx;
                        r_mul_a <= w_pick_a;
                        r_mul_b <= w_pick_b;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_lat   <= LAT_W'(MUL_LATENCY - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == '0) begin
                        r_out   <= mul_result;
                        r_state <= ST_WRITE;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (w_out_ready) begin
                        r_ptr   <= w_next_ptr;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd       = (r_state == ST_ISSUE) ? w_grant_oh : '0;
    assign wr       = (r_state == ST_WRITE && w_out_ready) ? w_grant_oh : '0;
    assign out_data = r_out;
    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign op_count = r_cnt;

endmodule

// File: tb/tb_kpn_mult_scheduler.sv
module tb_kpn_mult_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: NUM_REQ=2, MUL_LATENCY=1, CNT_W=16
    // Instance 1: NUM_REQ=2, MUL_LATENCY=3, CNT_W=4
    logic [1:0]  e_a [2] = '{2'b11, 2'b11};
    logic [1:0]  e_b [2] = '{2'b11, 2'b11};
    logic [31:0] ia  [2] = '{32'h0, 32'h0};
    logic [31:0] ib  [2] = '{32'h0, 32'h0};
    logic [1:0]  full[2] = '{2'b00, 2'b00};
    logic [1:0]  hold_b[2] = '{2'b00, 2'b00};
    logic [1:0]  rd_v[2];
    logic [1:0]  wr_v[2];
    logic [31:0] od  [2];
    logic [15:0] ma  [2];
    logic [15:0] mb  [2];
    logic        g   [2];
    logic        bz  [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [31:0] mr0;
    logic [31:0] p1 [3];

    kpn_mult_scheduler #(.NUM_REQ(2), .MUL_LATENCY(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_empty_a(e_a[0]), .in_empty_b(e_b[0]), .in_a(ia[0]), .in_b(ib[0]),
        .rd(rd_v[0]), .out_full(full[0]), .wr(wr_v[0]), .out_data(od[0]),
        .mul_a(ma[0]), .mul_b(mb[0]), .mul_result(mr0),
        .grant_id(g[0]), .busy(bz[0]), .op_count(cnt0)
    );

    kpn_mult_scheduler #(.NUM_REQ(2), .MUL_LATENCY(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_empty_a(e_a[1]), .in_empty_b(e_b[1]), .in_a(ia[1]), .in_b(ib[1]),
        .rd(rd_v[1]), .out_full(full[1]), .wr(wr_v[1]), .out_data(od[1]),
        .mul_a(ma[1]), .mul_b(mb[1]), .mul_result(p1[2]),
        .grant_id(g[1]), .busy(bz[1]), .op_count(cnt1)
    );

    // External multipliers: product appears MUL_LATENCY edges after the inputs.
    always @(posedge clk) begin
        mr0   <= 32'(ma[0]) * 32'(mb[0]);
        p1[0] <= 32'(ma[1]) * 32'(mb[1]);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    // Operand FIFOs: index inst*2+ch, entry {a,b}; popped on rd, presented FWFT.
    logic [31:0] fq [4][$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rd_v[i][c] && fq[i*2+c].size() > 0) void'(fq[i*2+c].pop_front());
                e_a[i][c] <= (fq[i*2+c].size() == 0);
                e_b[i][c] <= (fq[i*2+c].size() == 0) | hold_b[i][c];
                ia[i][16*c +: 16] <= (fq[i*2+c].size() > 0) ? fq[i*2+c][0][31:16] : 16'h0;
                ib[i][16*c +: 16] <= (fq[i*2+c].size() > 0) ? fq[i*2+c][0][15:0]  : 16'h0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // An op is tracked by its age since the pop cycle: age 0 pops, ages
    // 1..L wait for the product, age L+1 writes (repeating while full).
    logic        m_busy[2];
    int          m_ch  [2];
    int          m_age [2];
    int          m_ptr [2];
    logic [15:0] m_a   [2];
    logic [15:0] m_b   [2];
    logic [31:0] m_out [2];
    logic [15:0] m_cnt [2];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] cmask(input int i);
        return (i == 0) ? 16'hFFFF : 16'h000F;
    endfunction

    function automatic int pick(input int ptr, input logic [1:0] el);
        for (int k = 0; k < 2; k++)
            if (el[1'((ptr + k) % 2)]) return (ptr + k) % 2;
        return -1;
    endfunction

    function automatic logic [15:0] head16(input logic [31:0] bus, input int c);
        return bus[16*c +: 16];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0; m_ch[i] <= 0; m_age[i] <= 0; m_ptr[i] <= 0;
                m_a[i] <= '0; m_b[i] <= '0; m_out[i] <= '0; m_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_busy[i]) begin
                    if (pick(m_ptr[i], ~e_a[i] & ~e_b[i]) >= 0) begin
                        m_busy[i] <= 1'b1;
                        m_age[i]  <= 0;
                        m_ch[i]   <= pick(m_ptr[i], ~e_a[i] & ~e_b[i]);
                        m_a[i]    <= head16(ia[i], pick(m_ptr[i], ~e_a[i] & ~e_b[i]));
                        m_b[i]    <= head16(ib[i], pick(m_ptr[i], ~e_a[i] & ~e_b[i]));
                    end
                end else if (m_age[i] <= lat(i)) begin
                    m_age[i] <= m_age[i] + 1;
                    if (m_age[i] == lat(i)) m_out[i] <= 32'(m_a[i]) * 32'(m_b[i]);
                end else if (!full[i][1'(m_ch[i])]) begin
                    m_busy[i] <= 1'b0;
                    m_ptr[i]  <= (m_ch[i] + 1) % 2;
                    m_cnt[i]  <= (m_cnt[i] + 16'd1) & cmask(i);
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int i);
        if (m_busy[i] && m_age[i] == 0) return 32'd1 << m_ch[i];
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_wr(input int i);
        if (m_busy[i] && m_age[i] == lat(i) + 1 && !full[i][1'(m_ch[i])]) return 32'd1 << m_ch[i];
        return 32'd0;
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    int rd_ch_q[2][$];
    int rd_cy_q[2][$];
    int wr_cy_q[2][$];
    logic [31:0] wr_d_q[2][$];

    always @(posedge clk) begin
        #4;
        for (int i = 0; i < 2; i++) begin
            chk("busy",     i, 32'(bz[i]), 32'(m_busy[i]));
            chk("rd",       i, 32'(rd_v[i]), exp_rd(i));
            chk("wr",       i, 32'(wr_v[i]), exp_wr(i));
            chk("out_data", i, od[i], m_out[i]);
            chk("mul_a",    i, 32'(ma[i]), 32'(m_a[i]));
            chk("mul_b",    i, 32'(mb[i]), 32'(m_b[i]));
            chk("grant_id", i, 32'(g[i]), 32'(m_ch[i]));
            chk("op_count", i, (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_cnt[i]));
            if (rd_v[i] != 2'b00) begin
                rd_ch_q[i].push_back(rd_v[i] == 2'b10 ? 1 : 0);
                rd_cy_q[i].push_back(cyc);
            end
            if (wr_v[i] != 2'b00) begin
                wr_cy_q[i].push_back(cyc);
                wr_d_q[i].push_back(od[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int c, input logic [15:0] a, input logic [15:0] b);
        fq[i*2+c].push_back({a, b});
    endtask

    task automatic wait_wr(input int i, input int n, input int budget);
        int t = 0;
        while (wr_cy_q[i].size() < n && t < budget) begin
            step();
            t++;
        end
        chk("wr_count", i, 32'(wr_cy_q[i].size()), 32'(n));
    endtask

    task automatic wait_rd(input int i, input int budget);
        int t = 0;
        while (rd_v[i] == 2'b00 && t < budget) begin
            step();
            t++;
        end
        chk("rd_seen", i, 32'(rd_v[i] != 2'b00), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int wc;

        // Reset values
        step();
        chk("rst_busy", 0, 32'(bz[0]), 32'd0);
        chk("rst_rd",   0, 32'(rd_v[0]), 32'd0);
        chk("rst_wr",   0, 32'(wr_v[0]), 32'd0);
        chk("rst_data", 0, od[0], 32'd0);
        chk("rst_cnt",  0, 32'(cnt0), 32'd0);
        chk("rst_gid",  1, 32'(g[1]), 32'd0);
        step();
        rst = 1'b0;

        // Single op on ch0: 0x12 * 0x3 = 0x36, written two cycles after the pop
        push(0, 0, 16'h0012, 16'h0003);
        wait_wr(0, 1, 20);
        chk("t1_data", 0, wr_d_q[0][0], 32'h36);
        chk("t1_lat",  0, 32'(wr_cy_q[0][0] - rd_cy_q[0][0]), 32'd2);
        chk("t1_cnt",  0, 32'(cnt0), 32'd1);

        // Reset while waiting for the product: immediate return, no write
        push(0, 1, 16'h0100, 16'h0200);
        wait_rd(0, 20);
        step();
        rst = 1'b1;
        #1;
        chk("t5_busy", 0, 32'(bz[0]), 32'd0);
        chk("t5_rd",   0, 32'(rd_v[0]), 32'd0);
        chk("t5_wr",   0, 32'(wr_v[0]), 32'd0);
        chk("t5_data", 0, od[0], 32'd0);
        chk("t5_mula", 0, 32'(ma[0]), 32'd0);
        chk("t5_gid",  0, 32'(g[0]), 32'd0);
        chk("t5_cnt",  0, 32'(cnt0), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Both channels eligible: rotation 0,1,0,1 at one op per 4 cycles
        push(0, 0, 16'd2, 16'd3);  push(0, 0, 16'd4, 16'd5);
        push(0, 1, 16'd7, 16'd8);  push(0, 1, 16'd9, 16'd10);
        wait_wr(0, 5, 60);
        chk("t2_ord0", 0, 32'(rd_ch_q[0][2]), 32'd0);
        chk("t2_ord1", 0, 32'(rd_ch_q[0][3]), 32'd1);
        chk("t2_ord2", 0, 32'(rd_ch_q[0][4]), 32'd0);
        chk("t2_ord3", 0, 32'(rd_ch_q[0][5]), 32'd1);
        for (int k = 3; k <= 5; k++)
            chk("t2_period", 0, 32'(rd_cy_q[0][k] - rd_cy_q[0][k-1]), 32'd4);
        chk("t2_d0", 0, wr_d_q[0][1], 32'd6);
        chk("t2_d1", 0, wr_d_q[0][2], 32'd56);
        chk("t2_d2", 0, wr_d_q[0][3], 32'd20);
        chk("t2_d3", 0, wr_d_q[0][4], 32'd90);
        chk("t2_cnt", 0, 32'(cnt0), 32'd4);

        // Result FIFO of ch1 full for 10 WRITE cycles; ch0 request waits meanwhile
        full[0] = 2'b10;
        push(0, 1, 16'h1234, 16'h0010);
        wait_rd(0, 20);
        step();
        step();
        wc = cyc;
        push(0, 0, 16'h0003, 16'h0005);
        repeat (9) step();
        chk("t3_stall_busy", 0, 32'(bz[0]), 32'd1);
        chk("t3_stall_wr",   0, 32'(wr_v[0]), 32'd0);
        step();
        full[0] = 2'b00;
        wait_wr(0, 7, 30);
        chk("t3_wr_cycle", 0, 32'(wr_cy_q[0][5] - wc), 32'd10);
        chk("t3_d_ch1",    0, wr_d_q[0][5], 32'h0001_2340);
        chk("t3_d_ch0",    0, wr_d_q[0][6], 32'h0000_000F);
        chk("t3_next_ch",  0, 32'(rd_ch_q[0][7]), 32'd0);

        // Latency 3, 4-bit counter: 17 ops alternating channels
        for (int j = 0; j < 17; j++)
            push(1, j % 2, 16'h0100 + 16'(j), 16'h0003 + 16'(j));
        wait_wr(1, 17, 400);
        chk("t4_d0", 1, wr_d_q[1][0], 32'h0000_0300);
        chk("t4_d1", 1, wr_d_q[1][1], 32'h0000_0404);
        for (int j = 0; j < 17; j++) begin
            chk("t4_data", 1, wr_d_q[1][j], (32'h100 + 32'(j)) * (32'd3 + 32'(j)));
            chk("t4_ch",   1, 32'(rd_ch_q[1][j]), 32'(j % 2));
        end
        for (int j = 1; j < 17; j++)
            chk("t4_period", 1, 32'(rd_cy_q[1][j] - rd_cy_q[1][j-1]), 32'd6);
        chk("t4_lat", 1, 32'(wr_cy_q[1][0] - rd_cy_q[1][0]), 32'd4);
        chk("t6_cnt_wrap", 1, 32'(cnt1), 32'd1);

        // Operand B missing on ch0: nothing is eligible for 20 cycles
        hold_b[0] = 2'b01;
        push(0, 0, 16'h0007, 16'h0006);
        repeat (20) begin
            step();
            chk("idle_busy", 0, 32'(bz[0]), 32'd0);
            chk("idle_rd",   0, 32'(rd_v[0]), 32'd0);
            chk("idle_busy", 1, 32'(bz[1]), 32'd0);
            chk("idle_rd",   1, 32'(rd_v[1]), 32'd0);
        end
        hold_b[0] = 2'b00;
        wait_wr(0, 8, 20);
        chk("idle_release_d", 0, wr_d_q[0][7], 32'd42);
        chk("idle_release_ch", 0, 32'(rd_ch_q[0][8]), 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
